// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
// Shared definitions for the fabric configuration stream loader:
//   state_t            loader FSM states
//   MAGIC              expected header upper half
//   ERR_*              err_code values reported by the loader
//   DEFAULT_IDLE_ADDR  parked bus address (section 16'hFFFF is never decoded)
//   sat_inc16()        saturating 16-bit increment used for pairs_written
// -----------------------------------------------------------------------------
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [15:0] MAGIC = 16'hC0F1;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MAGIC    = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [31:0] DEFAULT_IDLE_ADDR = 32'hFFFF_FFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/loader_watchdog.sv
// -----------------------------------------------------------------------------
// loader_watchdog
// Counts idle cycles while the loader is waiting for a stream word.
// Ports:
//   clk        fabric clock
//   reset      asynchronous, active-low reset
//   i_clear    zero the counter (word accepted or FSM state change)
//   i_enable   count this cycle (ready and no valid word offered)
//   o_expired  this cycle's increment reaches TIMEOUT; the FSM leaves the
//              waiting state on the same edge, which also clears the counter
// -----------------------------------------------------------------------------
module loader_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // The counter never needs to hold TIMEOUT itself: expiry is flagged while
  // it still holds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/config_stream_loader.sv
// -----------------------------------------------------------------------------
// config_stream_loader
// Fabric configuration sequencer. Takes a valid/ready stream of 32-bit words
// (header, N address/data pairs, checksum), checks the header magic and a
// running XOR checksum, and drives each pair onto the shared config bus for
// HOLD_CYCLES cycles. Between pairs the bus parks on IDLE_ADDR with data 0.
// Ports:
//   clk            fabric clock
//   reset          asynchronous, active-low reset
//   start          single-cycle pulse, begins a load when idle
//   abort          level, cancels a load in progress
//   in_data        stream word
//   in_valid       stream word valid
//   in_ready       loader accepts in_data this cycle (from state only)
//   config_addr    config bus address [31:16] section, [15:0] tile_id
//   config_data    config bus data
//   busy           load in progress
//   done           sticky, last load completed with a good checksum
//   error          sticky, last load failed
//   err_code       0 none, 1 bad magic, 2 checksum mismatch, 3 timeout
//   pairs_written  pairs driven onto the bus in the current/last load
// -----------------------------------------------------------------------------
module config_stream_loader
  import config_loader_pkg::*;
#(
  parameter int          HOLD_CYCLES = 1,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] IDLE_ADDR   = DEFAULT_IDLE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] pairs_written
);

  state_t      r_state,      w_state_next;
  logic [31:0] r_addr_bus,   w_addr_bus_next;
  logic [31:0] r_data_bus,   w_data_bus_next;
  logic [31:0] r_pend_addr,  w_pend_addr_next;
  logic [15:0] r_remaining,  w_remaining_next;
  logic [3:0]  r_hold_cnt,   w_hold_next;
  logic [31:0] r_checksum,   w_checksum_next;
  logic [15:0] r_pairs,      w_pairs_next;
  logic        r_done,       w_done_next;
  logic        r_error,      w_error_next;
  logic [1:0]  r_err_code,   w_err_code_next;

  logic w_in_ready;
  logic w_busy;
  logic w_accept;
  logic w_wd_clear;
  logic w_wd_expired;

  assign w_in_ready = (r_state == ST_HDR) || (r_state == ST_ADDR) ||
                      (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign w_busy     = w_in_ready || (r_state == ST_WRITE);
  assign w_accept   = in_valid && w_in_ready;

  // Any accepted word or state change restarts the idle count.
  assign w_wd_clear = w_accept || (w_state_next != r_state);

  loader_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_in_ready && !in_valid),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr_bus  <= IDLE_ADDR;
      r_data_bus  <= '0;
      r_pend_addr <= '0;
      r_remaining <= '0;
      r_hold_cnt  <= '0;
      r_checksum  <= '0;
      r_pairs     <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_state     <= w_state_next;
      r_addr_bus  <= w_addr_bus_next;
      r_data_bus  <= w_data_bus_next;
      r_pend_addr <= w_pend_addr_next;
      r_remaining <= w_remaining_next;
      r_hold_cnt  <= w_hold_next;
      r_checksum  <= w_checksum_next;
      r_pairs     <= w_pairs_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
      r_err_code  <= w_err_code_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_addr_bus_next  = r_addr_bus;
    w_data_bus_next  = r_data_bus;
    w_pend_addr_next = r_pend_addr;
    w_remaining_next = r_remaining;
    w_hold_next      = r_hold_cnt;
    w_checksum_next  = r_checksum;
    w_pairs_next     = r_pairs;
    w_done_next      = r_done;
    w_error_next     = r_error;
    w_err_code_next  = r_err_code;

    case (r_state)
      ST_IDLE: begin
        // Simultaneous abort suppresses the start.
        if (start && !abort) begin
          w_state_next    = ST_HDR;
          w_done_next     = 1'b0;
          w_error_next    = 1'b0;
          w_err_code_next = ERR_NONE;
          w_pairs_next    = '0;
          w_checksum_next = '0;
        end
      end

      ST_HDR: begin
        if (w_wd_expired) begin
          w_state_next    = ST_ERROR;
          w_error_next    = 1'b1;
          w_err_code_next = ERR_TIMEOUT;
        end else if (w_accept) begin
          if (in_data[31:16] != MAGIC) begin
            w_state_next    = ST_ERROR;
            w_error_next    = 1'b1;
            w_err_code_next = ERR_MAGIC;
          end else begin
            w_checksum_next  = in_data;
            w_remaining_next = in_data[15:0];
            if (in_data[15:0] == 16'd0) begin
              w_state_next = ST_CHECK;
            end else begin
              w_state_next = ST_ADDR;
            end
          end
        end
      end

      ST_ADDR: begin
        if (w_wd_expired) begin
          w_state_next    = ST_ERROR;
          w_error_next    = 1'b1;
          w_err_code_next = ERR_TIMEOUT;
        end else if (w_accept) begin
          w_pend_addr_next = in_data;
          w_checksum_next  = r_checksum ^ in_data;
          w_state_next     = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_wd_expired) begin
          w_state_next    = ST_ERROR;
          w_error_next    = 1'b1;
          w_err_code_next = ERR_TIMEOUT;
        end else if (w_accept) begin
          // Address and data land on the bus on the same edge.
          w_checksum_next = r_checksum ^ in_data;
          w_addr_bus_next = r_pend_addr;
          w_data_bus_next = in_data;
          w_pairs_next    = sat_inc16(r_pairs);
          w_hold_next     = 4'(HOLD_CYCLES - 1);
          w_state_next    = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (r_hold_cnt == 4'd0) begin
          w_addr_bus_next  = IDLE_ADDR;
          w_data_bus_next  = '0;
          w_remaining_next = r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
            w_state_next = ST_CHECK;
          end else begin
            w_state_next = ST_ADDR;
          end
        end else begin
          w_hold_next = r_hold_cnt - 4'd1;
        end
      end

      ST_CHECK: begin
        if (w_wd_expired) begin
          w_state_next    = ST_ERROR;
          w_error_next    = 1'b1;
          w_err_code_next = ERR_TIMEOUT;
        end else if (w_accept) begin
          if (in_data == r_checksum) begin
            w_state_next = ST_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next    = ST_ERROR;
            w_error_next    = 1'b1;
            w_err_code_next = ERR_CHECKSUM;
          end
        end
      end

      ST_DONE:  w_state_next = ST_IDLE;
      ST_ERROR: w_state_next = ST_IDLE;

      default: begin
        w_state_next    = ST_IDLE;
        w_addr_bus_next = IDLE_ADDR;
        w_data_bus_next = '0;
      end
    endcase

    // Abort overrides everything above, including finishing a WRITE; the
    // pair count of the cancelled load is preserved.
    if (abort && w_busy) begin
      w_state_next    = ST_IDLE;
      w_addr_bus_next = IDLE_ADDR;
      w_data_bus_next = '0;
      w_pairs_next    = r_pairs;
      w_done_next     = 1'b0;
      w_error_next    = 1'b0;
      w_err_code_next = r_err_code;
    end
  end

  assign in_ready      = w_in_ready;
  assign busy          = w_busy;
  assign config_addr   = r_addr_bus;
  assign config_data   = r_data_bus;
  assign done          = r_done;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign pairs_written = r_pairs;

endmodule

// File: tb/tb_config_stream_loader.sv
// -----------------------------------------------------------------------------
// tb_config_stream_loader
// Self-checking bench for config_stream_loader (HOLD_CYCLES=3, TIMEOUT=16).
// Loads are built from random pairs; the expected bus trace and final status
// are derived directly from the stream contents, and a monitor collapses the
// observed bus into (addr, data, cycles held) runs for comparison.
// -----------------------------------------------------------------------------
module tb_config_stream_loader;

  localparam int          HOLD = 3;
  localparam int          TOUT = 16;
  localparam logic [31:0] PARK = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] pairs_written;

  config_stream_loader #(
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TOUT),
    .IDLE_ADDR   (PARK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .config_addr   (config_addr),
    .config_data   (config_data),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .pairs_written (pairs_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          len;
  } run_t;

  run_t mon_q[$];
  run_t cur;
  bit   in_run = 0;

  always @(negedge clk) begin
    if (!reset) begin
      in_run = 0;
    end else if (config_addr == PARK) begin
      check_value("park_data", config_data, 32'd0);
      if (in_run) begin
        mon_q.push_back(cur);
        in_run = 0;
      end
    end else begin
      if (in_run && cur.a == config_addr && cur.d == config_data) begin
        cur.len++;
      end else begin
        if (in_run) mon_q.push_back(cur);
        cur.a   = config_addr;
        cur.d   = config_data;
        cur.len = 1;
        in_run  = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] pa[$];
  logic [31:0] pd[$];

  task automatic fill_random(input int n);
    logic [15:0] sec;
    logic [31:0] r;
    pa.delete();
    pd.delete();
    for (int i = 0; i < n; i++) begin
      sec = 16'($urandom_range(0, 16'hFFFE));
      r   = $urandom();
      pa.push_back({sec, r[15:0]});
      pd.push_back($urandom());
    end
  endtask

  // Called just after a negedge; returns just after the negedge that follows
  // the accepting posedge.
  task automatic push(input logic [31:0] w, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_value("push_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return $urandom_range(0, 3);
  endfunction

  // Full load of the pairs in pa/pd; expected results follow from the stream.
  task automatic run_load(input bit corrupt, input int gap_mode, input bit glitch);
    int          n;
    logic [31:0] hdr;
    logic [31:0] sum;
    n   = pa.size();
    hdr = {16'hC0F1, 16'(n)};
    sum = hdr;
    for (int i = 0; i < n; i++) sum = sum ^ pa[i] ^ pd[i];
    if (corrupt) sum = sum ^ 32'd1;
    mon_q.delete();
    pulse_start();
    push(hdr, 0);
    if (glitch) begin
      start = 1'b1;   // ignored while busy
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      push(pa[i], pick_gap(gap_mode));
      push(pd[i], pick_gap(gap_mode));
    end
    push(sum, pick_gap(gap_mode));
    repeat (3) @(negedge clk);
    check_value("load_done",     32'(done),          corrupt ? 32'd0 : 32'd1);
    check_value("load_error",    32'(error),         corrupt ? 32'd1 : 32'd0);
    check_value("load_err_code", 32'(err_code),      corrupt ? 32'd2 : 32'd0);
    check_value("load_pairs",    32'(pairs_written), 32'(n));
    check_value("load_busy",     32'(busy),          32'd0);
    check_value("load_ready",    32'(in_ready),      32'd0);
    check_value("load_runs",     32'(mon_q.size()),  32'(n));
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      check_value("run_addr", mon_q[i].a,          pa[i]);
      check_value("run_data", mon_q[i].d,          pd[i]);
      check_value("run_len",  32'(mon_q[i].len),   32'(HOLD));
    end
    $display("load n=%0d corrupt=%0d gap_mode=%0d glitch=%0d done=%0b error=%0b code=%0d pairs=%0d",
             n, corrupt, gap_mode, glitch, done, error, err_code, pairs_written);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check_value("rst_addr",  config_addr,         PARK);
    check_value("rst_data",  config_data,         32'd0);
    check_value("rst_ready", 32'(in_ready),       32'd0);
    check_value("rst_busy",  32'(busy),           32'd0);
    check_value("rst_done",  32'(done),           32'd0);
    check_value("rst_error", 32'(error),          32'd0);
    check_value("rst_code",  32'(err_code),       32'd0);
    check_value("rst_pairs", 32'(pairs_written),  32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single pair from the example stream.
    pa.delete(); pd.delete();
    pa.push_back(32'h0004_0003);
    pd.push_back(32'h0000_0002);
    run_load(1'b0, 0, 1'b0);

    // Bad header.
    mon_q.delete();
    pulse_start();
    push(32'h1234_0002, 0);
    check_value("magic_error", 32'(error),    32'd1);
    check_value("magic_code",  32'(err_code), 32'd1);
    check_value("magic_done",  32'(done),     32'd0);
    repeat (2) @(negedge clk);
    check_value("magic_ready", 32'(in_ready),     32'd0);
    check_value("magic_bus",   32'(mon_q.size()), 32'd0);
    $display("bad header error=%0b code=%0d", error, err_code);

    // Two pairs with a wrong final word.
    fill_random(2);
    run_load(1'b1, 0, 1'b0);

    // Timeout: nothing offered after the header.
    pulse_start();
    push(32'hC0F1_0002, 0);
    repeat (TOUT - 1) @(negedge clk);
    check_value("tout_early_error", 32'(error), 32'd0);
    check_value("tout_early_busy",  32'(busy),  32'd1);
    @(negedge clk);
    check_value("tout_error", 32'(error),    32'd1);
    check_value("tout_code",  32'(err_code), 32'd3);
    $display("timeout error=%0b code=%0d", error, err_code);
    repeat (2) @(negedge clk);

    // Abort during the WRITE of pair 1 of 3.
    fill_random(3);
    pulse_start();
    push({16'hC0F1, 16'd3}, 0);
    push(pa[0], 0);
    push(pd[0], 0);
    check_value("abort_pre_addr", config_addr, pa[0]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_value("abort_addr",  config_addr,        PARK);
    check_value("abort_data",  config_data,        32'd0);
    check_value("abort_busy",  32'(busy),          32'd0);
    check_value("abort_done",  32'(done),          32'd0);
    check_value("abort_error", 32'(error),         32'd0);
    check_value("abort_pairs", 32'(pairs_written), 32'd1);
    $display("abort busy=%0b pairs=%0d", busy, pairs_written);
    repeat (2) @(negedge clk);

    // Back-pressure: valid every other cycle, four pairs.
    fill_random(4);
    run_load(1'b0, 1, 1'b0);

    // Empty load: header N=0 then its own value as checksum.
    fill_random(0);
    run_load(1'b0, 0, 1'b0);

    // start together with abort while idle: abort wins, done from last load stays.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_value("idle_abort_busy", 32'(busy),     32'd0);
    check_value("idle_abort_done", 32'(done),     32'd1);
    check_value("idle_abort_rdy",  32'(in_ready), 32'd0);
    $display("start+abort idle busy=%0b done=%0b", busy, done);

    // Randomized loads.
    for (int it = 0; it < 10; it++) begin
      fill_random($urandom_range(0, 5));
      run_load(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-WRITE.
    fill_random(2);
    pulse_start();
    push({16'hC0F1, 16'd2}, 0);
    push(pa[0], 0);
    push(pd[0], 0);
    #2 reset = 1'b0;
    #1;
    check_value("arst_addr",  config_addr,        PARK);
    check_value("arst_data",  config_data,        32'd0);
    check_value("arst_busy",  32'(busy),          32'd0);
    check_value("arst_ready", 32'(in_ready),      32'd0);
    check_value("arst_pairs", 32'(pairs_written), 32'd0);
    check_value("arst_done",  32'(done),          32'd0);
    $display("async reset addr=%h busy=%0b", config_addr, busy);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Recovery after reset.
    fill_random(2);
    run_load(1'b0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

endmodule
